// File: rtl/tune_pkg.sv
// Shared definitions for the NCO tuning command interpreter: opcodes,
// response bytes, FSM state type, tuning constants and clamped arithmetic.
package tune_pkg;

  // ASCII command opcodes
  localparam logic [7:0] OP_FREQ = 8'h46;  // 'F' + 8 bytes, MSB first
  localparam logic [7:0] OP_UP   = 8'h2B;  // '+'
  localparam logic [7:0] OP_DOWN = 8'h2D;  // '-'
  localparam logic [7:0] OP_STEP = 8'h53;  // 'S' + 1 byte
  localparam logic [7:0] OP_READ = 8'h3F;  // '?'
  localparam logic [7:0] OP_CLR  = 8'h43;  // 'C'

  // Response bytes
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  // Tuning constants for a 136 MHz sample clock; also used by NCO frequency tables
  localparam logic [63:0] RESET_INC_900K = 64'h01B1B1B1B1B1B1B1;
  localparam logic [63:0] STEP_FINE_1K   = 64'h00007B5CA45266E2;
  localparam logic [63:0] STEP_COARSE_9K = 64'h00045641C6E59DF0;
  localparam logic [63:0] INC_FLOOR      = 64'h0000000000000000;
  localparam logic [63:0] INC_CEIL_FS4   = 64'h4000000000000000;

  // Command interpreter states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_FREQ,
    ST_GET_STEP,
    ST_APPLY,
    ST_TX_LOAD,
    ST_TX_WAIT
  } tune_state_t;

  // Add with a 65-bit intermediate; saturate at the upper clamp
  function automatic logic [63:0] clamp_add(input logic [63:0] cur,
                                            input logic [63:0] step,
                                            input logic [63:0] hi);
    logic [64:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum > {1'b0, hi}) return hi;
    return sum[63:0];
  endfunction

  // Subtract with a 65-bit intermediate; a borrow or result under the floor
  // clamps to the floor so the word never wraps
  function automatic logic [63:0] clamp_sub(input logic [63:0] cur,
                                            input logic [63:0] step,
                                            input logic [63:0] lo);
    logic [64:0] diff;
    diff = {1'b0, cur} - {1'b0, step};
    if (diff[64] || (diff[63:0] < lo)) return lo;
    return diff[63:0];
  endfunction

  // Inclusive range check used for absolute loads
  function automatic logic in_range(input logic [63:0] val,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/tune_timeout.sv
// Inter-byte gap timer: loadable down-counter that restarts on every received
// byte and flags expiry once TIMEOUT_CLKS cycles pass with no restart.
module tune_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 1360000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] cnt;

  // Reload on restart, otherwise count down to zero while armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= LOAD_VAL;
    end else if (restart) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A restart on the same cycle as terminal count takes priority
  assign expire = enable && !restart && (cnt == '0);

endmodule

// File: rtl/tune_ctrl.sv
// UART command interpreter owning the carrier NCO phase increment.
// Parses received bytes, updates the 64-bit tuning word atomically and
// returns ack/readback bytes through the transmitter handshake.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | waiting for an opcode byte
//  ST_GET_FREQ | collecting the 8 payload bytes of an absolute load
//  ST_GET_STEP | collecting the step-select byte
//  ST_APPLY    | single cycle: update the register, queue 'K' or 'E'
//  ST_TX_LOAD  | waiting for the transmitter to go idle, then strobe tx_dv
//  ST_TX_WAIT  | waiting for tx_done; more bytes -> TX_LOAD, else IDLE
module tune_ctrl
  import tune_pkg::*;
#(
  parameter logic [63:0] RESET_INC    = RESET_INC_900K,
  parameter logic [63:0] STEP_FINE    = STEP_FINE_1K,
  parameter logic [63:0] STEP_COARSE  = STEP_COARSE_9K,
  parameter logic [63:0] MIN_INC      = INC_FLOOR,
  parameter logic [63:0] MAX_INC      = INC_CEIL_FS4,
  parameter int unsigned TIMEOUT_CLKS = 1360000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [63:0] phase_inc,
  output logic        step_sel,
  output logic        overrun
);

  tune_state_t  state;
  logic [7:0]   opcode;
  logic [63:0]  staging;
  logic [2:0]   byte_cnt;
  logic [63:0]  tx_shift;
  logic [3:0]   tx_cnt;
  logic [63:0]  step_val;
  logic         gap_armed;
  logic         gap_expire;

  assign step_val  = step_sel ? STEP_COARSE : STEP_FINE;
  assign gap_armed = (state == ST_GET_FREQ) || (state == ST_GET_STEP);

  tune_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .restart(rx_dv),
    .enable (gap_armed),
    .expire (gap_expire)
  );

  // Command FSM with registered outputs; phase_inc only changes in ST_APPLY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      opcode    <= 8'h00;
      staging   <= '0;
      byte_cnt  <= '0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
      phase_inc <= RESET_INC;
      step_sel  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      tx_dv <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_dv) begin
            opcode <= rx_byte;
            case (rx_byte)
              OP_FREQ: begin
                byte_cnt <= '0;
                staging  <= '0;
                state    <= ST_GET_FREQ;
              end
              OP_STEP: begin
                staging <= '0;
                state   <= ST_GET_STEP;
              end
              OP_UP, OP_DOWN, OP_CLR: begin
                state <= ST_APPLY;
              end
              OP_READ: begin
                tx_shift <= phase_inc;
                tx_cnt   <= 4'd8;
                state    <= ST_TX_LOAD;
              end
              default: begin
                tx_shift <= {RSP_ERR, 56'd0};
                tx_cnt   <= 4'd1;
                state    <= ST_TX_LOAD;
              end
            endcase
          end
        end

        ST_GET_FREQ: begin
          if (rx_dv) begin
            staging  <= {staging[55:0], rx_byte};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) state <= ST_APPLY;
          end else if (gap_expire) begin
            staging  <= '0;
            tx_shift <= {RSP_ERR, 56'd0};
            tx_cnt   <= 4'd1;
            state    <= ST_TX_LOAD;
          end
        end

        ST_GET_STEP: begin
          if (rx_dv) begin
            staging <= {56'd0, rx_byte};
            state   <= ST_APPLY;
          end else if (gap_expire) begin
            staging  <= '0;
            tx_shift <= {RSP_ERR, 56'd0};
            tx_cnt   <= 4'd1;
            state    <= ST_TX_LOAD;
          end
        end

        ST_APPLY: begin
          tx_shift <= {RSP_OK, 56'd0};
          tx_cnt   <= 4'd1;
          state    <= ST_TX_LOAD;
          case (opcode)
            OP_FREQ: begin
              if (in_range(staging, MIN_INC, MAX_INC)) phase_inc <= staging;
              else                                     tx_shift  <= {RSP_ERR, 56'd0};
            end
            OP_UP:   phase_inc <= clamp_add(phase_inc, step_val, MAX_INC);
            OP_DOWN: phase_inc <= clamp_sub(phase_inc, step_val, MIN_INC);
            OP_STEP: step_sel  <= staging[0];
            OP_CLR:  overrun   <= 1'b0;
            default: tx_shift  <= {RSP_ERR, 56'd0};
          endcase
        end

        ST_TX_LOAD: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= tx_shift[63:56];
            state   <= ST_TX_WAIT;
          end
        end

        ST_TX_WAIT: begin
          if (tx_done) begin
            tx_shift <= {tx_shift[55:0], 8'd0};
            tx_cnt   <= tx_cnt - 4'd1;
            state    <= (tx_cnt == 4'd1) ? ST_IDLE : ST_TX_LOAD;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Bytes arriving while busy are dropped; this set wins over a same-cycle clear
      if (rx_dv && ((state == ST_APPLY) || (state == ST_TX_LOAD) ||
                    (state == ST_TX_WAIT))) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tune_ctrl.sv
// Testbench for tune_ctrl: directed vector table, hand-written multi-cycle
// sequences and randomized commands against a behavioural model.
module tb_tune_ctrl;

  localparam int          T        = 200;
  localparam logic [63:0] RST_C    = 64'h01B1B1B1B1B1B1B1;
  localparam logic [63:0] FINE_C   = 64'h00007B5CA45266E2;
  localparam logic [63:0] COARSE_C = 64'h00045641C6E59DF0;
  localparam logic [63:0] MAX_C    = 64'h4000000000000000;
  localparam logic [7:0]  C_F = 8'h46, C_UP = 8'h2B, C_DN = 8'h2D, C_S = 8'h53;
  localparam logic [7:0]  C_RD = 8'h3F, C_CL = 8'h43, C_K = 8'h4B, C_E = 8'h45;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_active;
  logic        tx_done;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;
  logic        step_sel;
  logic        overrun;

  logic tx_busy = 1'b0, tx_hold = 1'b0, tx_done_r = 1'b0, tx_done_x = 1'b0;
  assign tx_active = tx_busy | tx_hold;
  assign tx_done   = tx_done_r | tx_done_x;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];

  logic [63:0] m_inc;
  logic        m_sel;
  logic        m_ovr;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] arg;
    logic [63:0] exp_inc;
    logic        exp_sel;
    logic [7:0]  exp_rsp;
  } vec_t;
  vec_t vecs[15];

  always #5 clk = ~clk;

  tune_ctrl #(.TIMEOUT_CLKS(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dv    (rx_dv),
    .rx_byte  (rx_byte),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .phase_inc(phase_inc),
    .step_sel (step_sel),
    .overrun  (overrun)
  );

  // UART transmitter model: capture each strobed byte, stay busy, then pulse done
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) begin
        int lat;
        got_q.push_back(tx_byte);
        tx_busy = 1'b1;
        lat = $urandom_range(1, 8);
        repeat (lat) begin
          @(negedge clk);
          checks++;
          if (tx_dv !== 1'b0) begin
            errors++;
            $display("FAIL tx_dv_while_busy: got %b required 0", tx_dv);
          end
        end
        tx_done_r = 1'b1;
        @(negedge clk);
        tx_done_r = 1'b0;
        tx_busy   = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  // Send a full command with random inter-byte gaps; optionally follow it with
  // a byte that lands while the response is still pending
  task automatic do_cmd(input logic [7:0] op, input logic [63:0] arg, input bit drop);
    send_byte(op);
    if (op == C_F) begin
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(arg[63-8*i -: 8]);
      end
    end else if (op == C_S) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(arg[7:0]);
    end
    if (drop) send_byte(8'($urandom_range(0, 255)));
  endtask

  // Expect n response bytes (n==1: data[7:0], n==8: data MSB first), then silence
  task automatic check_rsp(input string name, input int n, input logic [63:0] data);
    int w;
    logic [7:0] exp;
    w = 0;
    while (got_q.size() < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes required %0d", name, got_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp = (n == 1) ? data[7:0] : data[63-8*i -: 8];
        chk($sformatf("%s_byte%0d", name, i), {56'd0, got_q.pop_front()}, {56'd0, exp});
      end
    end
    repeat (20) @(negedge clk);
    chk({name, "_extra"}, 64'(got_q.size()), 64'd0);
    got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    got_q.delete();
    m_inc = RST_C;
    m_sel = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic chk_state(input string name);
    chk({name, "_inc"}, phase_inc, m_inc);
    chk({name, "_sel"}, {63'd0, step_sel}, {63'd0, m_sel});
    chk({name, "_ovr"}, {63'd0, overrun}, {63'd0, m_ovr});
  endtask

  initial begin
    logic [63:0] fval;
    logic [7:0]  op, lastb;
    logic [63:0] arg;
    int          kind, rn;
    logic [63:0] rdata;
    bit          drop, seen;

    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    chk("rst_inc", phase_inc, RST_C);
    chk("rst_txdv", {63'd0, tx_dv}, 64'd0);
    chk("rst_txbyte", {56'd0, tx_byte}, 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    m_inc = RST_C; m_sel = 1'b0; m_ovr = 1'b0;
    chk_state("post_rst");
    chk("post_rst_no_tx", 64'(got_q.size()), 64'd0);

    // Absolute load with exact latency check on the last byte
    fval = 64'h0104376A9DD10437;
    send_byte(C_F);
    for (int i = 0; i < 7; i++) send_byte(fval[63-8*i -: 8]);
    lastb = fval[7:0];
    send_byte(lastb);
    chk("lat_1clk_unchanged", phase_inc, RST_C);
    @(negedge clk);
    chk("lat_2clk_loaded", phase_inc, fval);
    chk("lat_2clk_no_txdv", {63'd0, tx_dv}, 64'd0);
    check_rsp("load_ack", 1, {56'd0, C_K});

    // Directed vector table from reset
    do_reset();
    vecs[0]  = '{C_UP, 64'd0, RST_C + FINE_C, 1'b0, C_K};
    vecs[1]  = '{C_S, 64'h01, RST_C + FINE_C, 1'b1, C_K};
    vecs[2]  = '{C_DN, 64'd0, RST_C + FINE_C - COARSE_C, 1'b1, C_K};
    vecs[3]  = '{C_F, 64'h0000100000000000, 64'h0000100000000000, 1'b1, C_K};
    vecs[4]  = '{C_DN, 64'd0, 64'd0, 1'b1, C_K};
    vecs[5]  = '{C_DN, 64'd0, 64'd0, 1'b1, C_K};
    vecs[6]  = '{C_F, 64'h8000000000000000, 64'd0, 1'b1, C_E};
    vecs[7]  = '{C_F, MAX_C, MAX_C, 1'b1, C_K};
    vecs[8]  = '{C_UP, 64'd0, MAX_C, 1'b1, C_K};
    vecs[9]  = '{C_S, 64'hFE, MAX_C, 1'b0, C_K};
    vecs[10] = '{8'h58, 64'd0, MAX_C, 1'b0, C_E};
    vecs[11] = '{C_F, MAX_C + 64'd1, MAX_C, 1'b0, C_E};
    vecs[12] = '{C_DN, 64'd0, MAX_C - FINE_C, 1'b0, C_K};
    vecs[13] = '{C_CL, 64'd0, MAX_C - FINE_C, 1'b0, C_K};
    vecs[14] = '{C_UP, 64'd0, MAX_C, 1'b0, C_K};
    for (int i = 0; i < 15; i++) begin
      do_cmd(vecs[i].op, vecs[i].arg, 1'b0);
      check_rsp($sformatf("vec%0d_rsp", i), 1, {56'd0, vecs[i].exp_rsp});
      chk($sformatf("vec%0d_inc", i), phase_inc, vecs[i].exp_inc);
      chk($sformatf("vec%0d_sel", i), {63'd0, step_sel}, {63'd0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_ovr", i), {63'd0, overrun}, 64'd0);
    end

    // Readback held off by a busy transmitter; stray tx_done pulses ignored
    tx_hold = 1'b1;
    send_byte(C_RD);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tx_done_x = (i % 10 == 5);
    end
    tx_done_x = 1'b0;
    chk("hold_no_tx", 64'(got_q.size()), 64'd0);
    tx_hold = 1'b0;
    check_rsp("readback", 8, MAX_C);

    // Timeout mid-load: no early response, then 'E' with phase unchanged
    send_byte(C_F);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    repeat (T - 50) @(negedge clk);
    chk("timeout_not_early", 64'(got_q.size()), 64'd0);
    check_rsp("timeout_f", 1, {56'd0, C_E});
    chk("timeout_f_inc", phase_inc, MAX_C);
    send_byte(C_S);
    check_rsp("timeout_s", 1, {56'd0, C_E});
    chk("timeout_s_sel", {63'd0, step_sel}, 64'd0);

    // Gaps just under the timeout keep the command alive
    fval = 64'h0000000012345678;
    send_byte(C_F);
    for (int i = 0; i < 8; i++) begin
      repeat (T - 10) @(negedge clk);
      send_byte(fval[63-8*i -: 8]);
    end
    check_rsp("long_gap", 1, {56'd0, C_K});
    chk("long_gap_inc", phase_inc, fval);

    // Byte during transmit sets overrun and is not interpreted; 'C' clears it
    do_cmd(C_RD, 64'd0, 1'b1);
    check_rsp("ovr_readback", 8, fval);
    chk("ovr_set", {63'd0, overrun}, 64'd1);
    do_cmd(C_CL, 64'd0, 1'b0);
    check_rsp("ovr_clr", 1, {56'd0, C_K});
    chk("ovr_cleared", {63'd0, overrun}, 64'd0);

    // Reset mid-command discards the partial payload
    send_byte(C_F); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_inc", phase_inc, RST_C);
    chk("rst_mid_txdv", {63'd0, tx_dv}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_cmd(C_UP, 64'd0, 1'b0);
    check_rsp("rst_mid_up", 1, {56'd0, C_K});
    chk("rst_mid_up_inc", phase_inc, RST_C + FINE_C);

    // Reset while tx_dv is high drops it immediately
    send_byte(C_RD);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (tx_dv === 1'b1) seen = 1'b1;
    end
    chk("rst_tx_seen", {63'd0, seen}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_tx_txdv", {63'd0, tx_dv}, 64'd0);
    chk("rst_tx_inc", phase_inc, RST_C);
    do_reset();

    // Randomized commands against the behavioural model
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      arg  = 64'd0;
      rn   = 1;
      rdata = {56'd0, C_K};
      case (kind)
        0, 1: begin
          op  = C_F;
          arg = ($urandom_range(0, 5) == 0) ? MAX_C
                : ({$urandom, $urandom} >> $urandom_range(2, 63));
          m_inc = arg;
        end
        2: begin
          op  = C_F;
          arg = MAX_C + 64'd1 + ({$urandom, $urandom} >> $urandom_range(2, 63));
          rdata = {56'd0, C_E};
        end
        3: begin
          op = C_UP;
          if (m_inc > MAX_C - (m_sel ? COARSE_C : FINE_C)) m_inc = MAX_C;
          else m_inc = m_inc + (m_sel ? COARSE_C : FINE_C);
        end
        4: begin
          op = C_DN;
          if (m_inc < (m_sel ? COARSE_C : FINE_C)) m_inc = 64'd0;
          else m_inc = m_inc - (m_sel ? COARSE_C : FINE_C);
        end
        5: begin
          op  = C_S;
          arg = {56'd0, 8'($urandom_range(0, 255))};
          m_sel = arg[0];
        end
        6: begin
          op = C_RD;
          rn = 8;
          rdata = m_inc;
        end
        7: begin
          op = C_CL;
          m_ovr = 1'b0;
        end
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == C_F || op == C_UP || op == C_DN || op == C_S ||
                 op == C_RD || op == C_CL) op = 8'($urandom_range(0, 255));
          rdata = {56'd0, C_E};
        end
      endcase
      drop = ($urandom_range(0, 3) == 0);
      if (drop) m_ovr = 1'b1;
      do_cmd(op, arg, drop);
      check_rsp($sformatf("rnd%0d_rsp", n), rn, rdata);
      chk_state($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tune_ctrl.md
Name: tune_ctrl

Overview:
- UART command interpreter that owns the NCO tuning word; sits directly upstream of the carrier NCO.
- Consumes received bytes from the UART receiver and drives the 64-bit phase increment into the NCO.
- Returns ack/readback bytes through the UART transmitter handshake.
- Supports absolute tuning, 1 kHz / 9 kHz stepping and readback, so the receiver retunes without re-synthesis.

Parameters:
- RESET_INC, 64'h01B1B1B1B1B1B1B1, phase increment after reset (900 kHz at 136 MHz).
- STEP_FINE, 64'h00007B5CA45266E2, 1 kHz step.
- STEP_COARSE, 64'h00045641C6E59DF0, 9 kHz step.
- MIN_INC, 64'h0000000000000000, lower clamp.
- MAX_INC, 64'h4000000000000000, upper clamp (Fclk/4).
- TIMEOUT_CLKS, 1360000, maximum inter-byte gap inside a multi-byte command (10 ms).

Ports:
- clk  in  1  system clock (osc_clk domain).
- rst  in  1  asynchronous reset, active-low.
- rx_dv  in  1  one-cycle strobe: rx_byte valid.
- rx_byte  in  8  received byte.
- tx_active  in  1  transmitter busy.
- tx_done  in  1  one-cycle strobe: byte sent.
- tx_dv  out  1  one-cycle strobe: send tx_byte.
- tx_byte  out  8  byte to send.
- phase_inc  out  64  NCO phase increment.
- step_sel  out  1  0 = fine step, 1 = coarse step.
- overrun  out  1  sticky flag: rx byte dropped.

Behaviour:
- Reset values: phase_inc = RESET_INC, step_sel = 0, tx_dv = 0, tx_byte = 0, overrun = 0, state = IDLE.
- Commands (ASCII):
  - 'F' (0x46) + 8 payload bytes, MSB first: absolute load.
  - '+' (0x2B) step up; '-' (0x2D) step down.
  - 'S' (0x53) + 1 byte: step_sel = byte[0].
  - '?' (0x3F): readback.
  - 'C' (0x43): clear overrun.
- Responses:
  - Every completed command except '?' returns 'K' (0x4B).
  - Unknown opcode, timeout or out-of-range load returns 'E' (0x45).
  - '?' returns 8 bytes of phase_inc, MSB first, with no trailing 'K'.
- States and transitions:
  - IDLE: on rx_dv, decode the opcode. F → GET_FREQ (byte count 0). S → GET_STEP. +/−/C → APPLY. ? → snapshot phase_inc into the tx shift register, count 8, go to TX_LOAD. Other → queue 'E', go to TX_LOAD.
  - GET_FREQ: each rx_dv shifts the byte into a 64-bit staging register. After the 8th byte → APPLY.
  - GET_STEP: on rx_dv → APPLY.
  - APPLY: exactly one cycle. Updates the register, queues 'K' or 'E', goes to TX_LOAD.
  - TX_LOAD: waits until tx_active = 0, then pulses tx_dv for one cycle with tx_byte → TX_WAIT.
  - TX_WAIT: on tx_done, decrement the count. Count nonzero → TX_LOAD with the next byte; zero → IDLE.
- phase_inc update timing:
  - Changes only in APPLY, all 64 bits in one edge; the NCO never sees a partially loaded word.
  - Latency: last rx_dv of a command → phase_inc updated 2 clocks later.
  - First tx_dv follows at least 1 clock after that.
- Arithmetic: 64-bit unsigned with a 65-bit intermediate.
  - '+': result = min(phase_inc + step, MAX_INC).
  - '-': result = max(phase_inc − step, MIN_INC). Underflow (borrow) clamps to MIN_INC; never wraps.
  - 'F' payload > MAX_INC or < MIN_INC: phase_inc unchanged, respond 'E'.
- Timeout: in GET_FREQ/GET_STEP a gap counter restarts on every rx_dv. Reaching TIMEOUT_CLKS discards the staging register, queues 'E', goes to TX_LOAD.
- rx_dv while in APPLY/TX_LOAD/TX_WAIT: byte dropped, overrun = 1. overrun clears only on the 'C' command or on reset.
- rx_dv and timeout expiry on the same cycle: the byte wins and the counter restarts.
- tx_done while in TX_LOAD: ignored.
- Reset mid-command or mid-transmit: immediate return to reset values, partial payload discarded, tx_dv low in the same cycle reset asserts.

Decomposition:
- Shared package tune_pkg: opcode constants (OP_FREQ, OP_UP, OP_DOWN, OP_STEP, OP_READ, OP_CLR, RSP_OK, RSP_ERR), the state enum, and the step constants reused by NCO frequency tables.
- One sub-module, tune_timeout: loadable down-counter with restart/expire, width clog2(TIMEOUT_CLKS).

Test Plan:
- Reset then release: phase_inc = 64'h01B1B1B1B1B1B1B1, step_sel = 0, overrun = 0, no tx_dv.
- 'F' + 01 04 37 6A 9D D1 04 37 → phase_inc = 64'h0104376A9DD10437 two clocks after the last byte; exactly one tx_dv with 0x4B.
- From reset: '+' → 64'h01B1B1B1B1B1B1B1 + 64'h7B5CA45266E2. Then 'S'+0x01, '-' → value minus 64'h45641C6E59DF0, step_sel = 1.
- Load 64'h0000100000000000, step_sel = 1, send '-' → phase_inc = 0 (clamped). 'F' with 64'h8000000000000000 → 'E', phase_inc unchanged.
- '?' with tx_active held high 50 clocks → no tx_dv until it drops. Then 8 bytes in MSB-first order, each only after tx_done.
- 'F' + 3 bytes then silence > TIMEOUT_CLKS → 'E', phase_inc unchanged. Byte sent during TX_WAIT → overrun = 1; 'C' → overrun = 0, response 'K'.
